// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: RV32I load/store func3
// encodings, the responder FSM state type and the latency counter width.
// -----------------------------------------------------------------------------
package dmem_pkg;

    // RV32I func3 size encodings (loads use all five, stores the first three)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for the maximum legal LATENCY of 15
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } dmem_state_t;

    // Stores only support B/H/W; loads add the unsigned byte/half variants.
    function automatic logic size_legal(input logic we, input logic [2:0] size);
        logic ok;
        ok = (size == F3_B) || (size == F3_H) || (size == F3_W);
        if (!we) begin
            ok = ok || (size == F3_BU) || (size == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane steering between the RV32I load/store view and a
// 32-bit word-organised RAM.
//   addr_lo    in   2   byte offset within the word (addr[1:0])
//   size       in   3   RV32I func3
//   wdata      in   32  store data, byte in [7:0], half in [15:0]
//   rword      in   32  word read from RAM
//   byte_en    out  4   per-lane write enables for the store
//   wdata_lane out  32  store data replicated onto every lane it may occupy
//   misalign   out  1   half not on a 2-byte boundary / word not on 4-byte
//   rdata_ext  out  32  selected lane(s) of rword, sign or zero extended
// Illegal size codes yield no enables, no misalign and zero read data; the
// caller is responsible for flagging them.
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic        misalign,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte      = rword[{addr_lo, 3'b000} +: 8];
        rhalf      = addr_lo[1] ? rword[31:16] : rword[15:0];
        byte_en    = '0;
        wdata_lane = '0;
        misalign   = 1'b0;
        rdata_ext  = '0;
        case (size)
            F3_B, F3_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (size == F3_B) ? {{24{rbyte[7]}}, rbyte}
                                            : {24'h000000, rbyte};
            end
            F3_H, F3_HU: begin
                misalign   = addr_lo[0];
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (size == F3_H) ? {{16{rhalf[15]}}, rhalf}
                                            : {16'h0000, rhalf};
            end
            F3_W: begin
                misalign   = (addr_lo != 2'b00);
                byte_en    = '1;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Responder end of the core's data-memory interface. Accepts one load/store at
// a time, waits LATENCY cycles, then presents read data or an error until the
// initiator takes it. Backed by a DEPTH x 32-bit RAM with byte write enables.
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous reset, active-high
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept (IDLE only)
//   req_we      in   1   1 = store, 0 = load
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data
//   req_size    in   3   RV32I func3
//   resp_valid  out  1   response present, held until resp_ready
//   resp_ready  in   1   initiator takes response
//   resp_rdata  out  32  extended load data; 0 for stores and errors
//   resp_err    out  1   misaligned, out-of-range or illegal size
// Parameters: DEPTH (words), LATENCY (accept-to-resp_valid cycles, 1..15).
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [31:0] mem [0:DEPTH-1];

    dmem_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         size_q, size_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;

    // With LATENCY==1 the FSM enters RESP on the accept edge itself, before the
    // request is latched, so the commit path looks straight at the inputs then.
    logic               cur_we;
    logic [31:0]        cur_addr;
    logic [31:0]        cur_wdata;
    logic [2:0]         cur_size;
    logic [ADDR_W-1:0]  cur_idx;
    logic               cur_oor;
    logic               cur_err;
    logic [31:0]        rword;
    logic [3:0]         byte_en;
    logic [31:0]        wdata_lane;
    logic               misalign;
    logic [31:0]        rdata_ext;
    logic               commit;
    logic               do_write;

    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_size  = req_size;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_size  = size_q;
        end
        cur_idx = cur_addr[ADDR_W+1:2];
        cur_oor = ({2'b00, cur_addr[31:2]} >= DEPTH);
        rword   = mem[cur_idx];
    end

    dmem_lane_align u_align (
        .addr_lo    (cur_addr[1:0]),
        .size       (cur_size),
        .wdata      (cur_wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .misalign   (misalign),
        .rdata_ext  (rdata_ext)
    );

    always_comb begin
        cur_err = !size_legal(cur_we, cur_size) || misalign || cur_oor;

        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The RAM access (read or write) happens on the edge entering RESP.
        commit   = (state_d == S_RESP) && (state_q != S_RESP);
        do_write = commit && !rst && cur_we && !cur_err;

        if (commit) begin
            resp_err_d   = cur_err;
            resp_rdata_d = (cur_err || cur_we) ? '0 : rdata_ext;
        end

        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[cur_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, rst3, req_valid2, req_valid3;
    logic        req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;

    logic        req_ready2, resp_valid2, resp_err2;
    logic [31:0] resp_rdata2;
    logic        req_ready3, resp_valid3, resp_err3;
    logic [31:0] resp_rdata3;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .resp_valid(resp_valid2), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata2), .resp_err(resp_err2)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .resp_valid(resp_valid3), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3)
    );

    // Selects which instance the transaction task drives and observes.
    logic        dsel;
    logic        obs_ready, obs_valid, obs_err;
    logic [31:0] obs_rdata;
    assign obs_ready = dsel ? req_ready3  : req_ready2;
    assign obs_valid = dsel ? resp_valid3 : resp_valid2;
    assign obs_err   = dsel ? resp_err3   : resp_err2;
    assign obs_rdata = dsel ? resp_rdata3 : resp_rdata2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] ref_mem [0:DEPTH-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one request against ref_mem.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, output logic [31:0] rd, output logic err);
        logic        ok_size;
        logic [31:0] w;
        int unsigned idx, sh;
        if (we) ok_size = (size == F3_B) || (size == F3_H) || (size == F3_W);
        else    ok_size = (size == F3_B) || (size == F3_H) || (size == F3_W) ||
                          (size == F3_BU) || (size == F3_HU);
        err = !ok_size
            || (((size == F3_H) || (size == F3_HU)) && addr[0])
            || ((size == F3_W) && (addr[1:0] != 2'b00))
            || (32'(addr[31:2]) >= DEPTH);
        rd = '0;
        if (!err) begin
            idx = 32'(addr[31:2]);
            sh  = 8 * int'(addr[1:0]);
            w   = ref_mem[idx];
            if (we) begin
                case (size)
                    F3_B:    w[sh +: 8]  = wdata[7:0];
                    F3_H:    w[sh +: 16] = wdata[15:0];
                    default: w = wdata;
                endcase
                ref_mem[idx] = w;
            end else begin
                case (size)
                    F3_B:    rd = {{24{w[sh+7]}}, w[sh +: 8]};
                    F3_BU:   rd = {24'h000000, w[sh +: 8]};
                    F3_H:    rd = {{16{w[sh+15]}}, w[sh +: 16]};
                    F3_HU:   rd = {16'h0000, w[sh +: 16]};
                    default: rd = w;
                endcase
            end
        end
    endtask

    // One request/response. Literal expectations are used for the directed
    // cases; otherwise the model supplies them. hold = cycles to withhold
    // resp_ready once the response appears.
    task automatic txn(input logic sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size,
                       input bit use_lit, input logic [31:0] lit_rd, input logic lit_err,
                       input int unsigned hold, input int unsigned lat);
        exp_t        e;
        logic [31:0] rd, held;
        logic        er;
        int unsigned cyc;
        dsel = sel;
        cyc  = 0;
        while (obs_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (obs_ready !== 1'b1) begin
            check("ready_timeout", {31'b0, obs_ready}, 32'd1);
            return;
        end
        rd = '0;
        er = 1'b0;
        if (!sel) model(we, addr, wdata, size, rd, er);
        if (use_lit) begin
            e.rdata = lit_rd;
            e.err   = lit_err;
        end else begin
            e.rdata = rd;
            e.err   = er;
        end
        sb_q.push_back(e);

        resp_ready = (hold == 0);
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        if (sel) req_valid3 = 1'b1;
        else     req_valid2 = 1'b1;
        @(negedge clk);
        req_valid2 = 1'b0;
        req_valid3 = 1'b0;
        cyc = 1;
        while (obs_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, lat);
        e = sb_q.pop_front();
        if (obs_valid !== 1'b1) begin
            resp_ready = 1'b1;
            return;
        end
        check("rdata", obs_rdata, e.rdata);
        check("err", {31'b0, obs_err}, {31'b0, e.err});
        if (hold > 0) begin
            held = obs_rdata;
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", {31'b0, obs_valid}, 32'd1);
                check("hold_rdata", obs_rdata, held);
                check("hold_ready", {31'b0, obs_ready}, 32'd0);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        check("resp_drop", {31'b0, obs_valid}, 32'd0);
        check("ready_back", {31'b0, obs_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        rwe;
        logic [31:0] raddr;
        logic [2:0]  rsize;
        int unsigned cyc;

        dsel = 1'b0;
        rst2 = 1'b1; rst3 = 1'b1;
        req_valid2 = 1'b0; req_valid3 = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst2 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        check("rst_ready2", {31'b0, req_ready2}, 32'd1);
        check("rst_valid2", {31'b0, resp_valid2}, 32'd0);
        check("rst_rdata2", resp_rdata2, 32'd0);
        check("rst_err2", {31'b0, resp_err2}, 32'd0);
        check("rst_ready3", {31'b0, req_ready3}, 32'd1);
        check("rst_valid3", {31'b0, resp_valid3}, 32'd0);

        // Store then load of the same word
        txn(0, 1, 32'h10, 32'hDEADBEEF, F3_W, 1, 32'h0, 0, 0, 2);
        txn(0, 0, 32'h10, 32'h0, F3_W, 1, 32'hDEADBEEF, 0, 0, 2);

        // Load sizing and extension
        txn(0, 1, 32'h10, 32'h80FF7F01, F3_W, 1, 32'h0, 0, 0, 2);
        txn(0, 0, 32'h13, 32'h0, F3_B,  1, 32'hFFFFFF80, 0, 0, 2);
        txn(0, 0, 32'h13, 32'h0, F3_BU, 1, 32'h00000080, 0, 0, 2);
        txn(0, 0, 32'h12, 32'h0, F3_H,  1, 32'hFFFF80FF, 0, 0, 2);
        txn(0, 0, 32'h10, 32'h0, F3_HU, 1, 32'h00007F01, 0, 0, 2);

        // Byte-lane merging on stores
        txn(0, 1, 32'h10, 32'h0, F3_W, 1, 32'h0, 0, 0, 2);
        txn(0, 1, 32'h11, 32'hFFFFFFAA, F3_B, 1, 32'h0, 0, 0, 2);
        txn(0, 1, 32'h12, 32'hFFFF1234, F3_H, 1, 32'h0, 0, 0, 2);
        txn(0, 0, 32'h10, 32'h0, F3_W, 1, 32'h1234AA00, 0, 0, 2);

        // Error cases leave memory untouched
        txn(0, 0, 32'h12, 32'h0, F3_W, 1, 32'h0, 1, 0, 2);
        txn(0, 1, 32'h11, 32'h0000FFFF, F3_H, 1, 32'h0, 1, 0, 2);
        txn(0, 0, 32'h10, 32'h0, 3'b011, 1, 32'h0, 1, 0, 2);
        txn(0, 1, 32'h10, 32'h11111111, 3'b011, 1, 32'h0, 1, 0, 2);
        txn(0, 1, 32'h10, 32'h22222222, F3_BU, 1, 32'h0, 1, 0, 2);
        txn(0, 1, 4*DEPTH, 32'h33333333, F3_W, 1, 32'h0, 1, 0, 2);
        txn(0, 0, 4*DEPTH, 32'h0, F3_W, 1, 32'h0, 1, 0, 2);
        txn(0, 0, 32'h10, 32'h0, F3_W, 1, 32'h1234AA00, 0, 0, 2);

        // Back-pressure on the response, then an immediate follow-up request
        txn(0, 0, 32'h10, 32'h0, F3_W, 1, 32'h1234AA00, 0, 5, 2);
        txn(0, 1, 32'h14, 32'hCAFEF00D, F3_W, 1, 32'h0, 0, 0, 2);
        txn(0, 0, 32'h14, 32'h0, F3_W, 1, 32'hCAFEF00D, 0, 0, 2);

        // Model-checked random traffic over words 0..15
        for (int unsigned i = 0; i < 16; i++) begin
            txn(0, 1, 32'(4 * i), 32'(i * 32'h01010101), F3_W, 0, 32'h0, 0, 0, 2);
        end
        for (int unsigned i = 0; i < 40; i++) begin
            rwe   = 1'($urandom_range(0, 1));
            raddr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) raddr = raddr | (4 * DEPTH);
            rsize = 3'($urandom_range(0, 7));
            txn(0, rwe, raddr, $urandom, rsize, 0, 32'h0, 0, 0, 2);
        end

        // LATENCY=3 instance: a store reset while in WAIT is dropped
        txn(1, 1, 32'h20, 32'h12345678, F3_W, 1, 32'h0, 0, 0, 3);
        dsel = 1'b1;
        cyc  = 0;
        while (req_ready3 !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("l3_ready", {31'b0, req_ready3}, 32'd1);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h00000055; req_size = F3_W;
        req_valid3 = 1'b1;
        @(negedge clk);
        req_valid3 = 1'b0;
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        repeat (6) begin
            check("rst_no_resp", {31'b0, resp_valid3}, 32'd0);
            @(negedge clk);
        end
        check("rst_ready_back", {31'b0, req_ready3}, 32'd1);
        txn(1, 0, 32'h20, 32'h0, F3_W, 1, 32'h12345678, 0, 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
